// File: rtl/cs_pkg.sv
// Shared types and width helpers for the computational-system window filter.
// Imported by the filter top level and its reduction tree.
package cs_pkg;

    typedef enum logic [1:0] {
        CS_APPR = 2'd0,
        CS_MEAN = 2'd1,
        CS_MAX  = 2'd2,
        CS_MIN  = 2'd3
    } cs_mode_e;

    typedef enum logic [1:0] {
        RED_MAX_BELOW = 2'd0,
        RED_MAX       = 2'd1,
        RED_MIN       = 2'd2
    } cs_red_sel_e;

    localparam int unsigned CS_DATA_W = 8;
    localparam int unsigned CS_DEPTH  = 9;

    function automatic int unsigned cs_sum_w(input int unsigned dw, input int unsigned depth);
        return dw + $clog2(depth);
    endfunction

    function automatic int unsigned cs_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned cs_floor_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((v >> i) != 0) r = i;
        end
        return r;
    endfunction

    localparam int unsigned CS_SUM_W = cs_sum_w(CS_DATA_W, CS_DEPTH);
    localparam int unsigned CS_CNT_W = cs_cnt_w(CS_DEPTH);

endpackage

// File: rtl/cs_reduce_tree.sv
// Balanced pairwise reduction over N values: max, min, or max of values <= threshold.
// A node carries a valid bit so filtered-out leaves and padding never win; empty result is 0.
module cs_reduce_tree
    import cs_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N      = 9
) (
    input  logic [N-1:0][DATA_W-1:0] vals,
    input  logic [DATA_W-1:0]        thresh,
    input  cs_red_sel_e              sel,
    output logic [DATA_W-1:0]        result
);

    localparam int unsigned LV = $clog2(N);
    localparam int unsigned P  = 1 << LV;

    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int unsigned W = P >> l;
        logic [DATA_W-1:0] val [W];
        logic              vld [W];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < W; i++) begin : g_node
                if (i < N) begin : g_real
                    assign val[i] = vals[i];
                    assign vld[i] = (sel != RED_MAX_BELOW) || (vals[i] <= thresh);
                end else begin : g_pad
                    assign val[i] = '0;
                    assign vld[i] = 1'b0;
                end
            end
        end else begin : g_inner
            for (genvar i = 0; i < W; i++) begin : g_node
                logic [DATA_W-1:0] a, b;
                logic              av, bv, pick_a;
                assign a  = g_lvl[l-1].val[2*i];
                assign b  = g_lvl[l-1].val[2*i+1];
                assign av = g_lvl[l-1].vld[2*i];
                assign bv = g_lvl[l-1].vld[2*i+1];
                assign pick_a = !bv || (av && ((sel == RED_MIN) ? (a <= b) : (a >= b)));
                assign val[i] = pick_a ? a : b;
                assign vld[i] = av | bv;
            end
        end
    end

    assign result = g_lvl[LV].vld[0] ? g_lvl[LV].val[0] : '0;

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window filter: DEPTH-sample window with running sum, producing one registered
// APPR / MEAN / MAX / MIN result per accepted sample once the window is full.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        mode,
    input  logic              flush,
    output logic [DATA_W+1:0] y,
    output logic              y_valid,
    output logic              full
);

    localparam int unsigned SUM_W  = cs_sum_w(DATA_W, DEPTH);
    localparam int unsigned CNT_W  = cs_cnt_w(DEPTH);
    localparam int unsigned SHIFT  = cs_floor_log2(DEPTH);
    localparam int unsigned APPR_W = SUM_W + 1;
    localparam int unsigned YW     = DATA_W + 2;

    logic [DATA_W-1:0] w_q [DEPTH];
    logic [DATA_W-1:0] w_d [DEPTH];
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cs_mode_e          mode_q, mode_d;
    logic              pend_q, pend_d;
    logic [YW-1:0]     y_q;
    logic              y_valid_q;

    logic [DEPTH-1:0][DATA_W-1:0] tree_vals;
    logic [DATA_W-1:0]            avg;
    logic [DATA_W-1:0]            red_val;
    cs_red_sel_e                  red_sel;
    logic [APPR_W-1:0]            appr_sum;
    logic [YW-1:0]                res;

    // Window, sum and count next state; flush wins over the shift.
    always_comb begin
        w_d    = w_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        pend_d = 1'b0;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) w_d[i] = '0;
            sum_d = '0;
            cnt_d = '0;
            if (in_valid) begin
                w_d[0] = x;
                sum_d  = SUM_W'(x);
                cnt_d  = CNT_W'(1);
            end
        end else if (in_valid) begin
            for (int i = DEPTH - 1; i > 0; i--) w_d[i] = w_q[i-1];
            w_d[0] = x;
            sum_d  = sum_q - SUM_W'(w_q[DEPTH-1]) + SUM_W'(x);
            if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (in_valid) begin
            mode_d = cs_mode_e'(mode);
            pend_d = (cnt_d == CNT_W'(DEPTH));
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) tree_vals[i] = w_q[i];
    end

    assign avg = DATA_W'(sum_q / SUM_W'(DEPTH));

    always_comb begin
        red_sel = RED_MAX_BELOW;
        unique case (mode_q)
            CS_MAX:  red_sel = RED_MAX;
            CS_MIN:  red_sel = RED_MIN;
            default: red_sel = RED_MAX_BELOW;
        endcase
    end

    cs_reduce_tree #(
        .DATA_W (DATA_W),
        .N      (DEPTH)
    ) u_reduce (
        .vals   (tree_vals),
        .thresh (avg),
        .sel    (red_sel),
        .result (red_val)
    );

    // Wide enough for DEPTH*max + sum, so the sum never wraps before the shift.
    assign appr_sum = APPR_W'(DEPTH) * APPR_W'(red_val) + APPR_W'(sum_q);

    always_comb begin
        res = '0;
        unique case (mode_q)
            CS_APPR: res = YW'(appr_sum >> SHIFT);
            CS_MEAN: res = YW'(avg);
            CS_MAX:  res = YW'(red_val);
            CS_MIN:  res = YW'(red_val);
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) w_q[i] <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= CS_APPR;
            pend_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            w_q       <= w_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            y_valid_q <= pend_q;
            if (pend_q) y_q <= res;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign full    = (cnt_q == CNT_W'(DEPTH));

endmodule
